// File: rtl/ysyx_mem_arb.sv
// Two-master (IFU / LSU) arbiter and sequencer onto one AXI-lite-style memory port.
// Handles round-robin grant on ties, store strobe/data alignment and load extraction.
module ysyx_mem_arb #(
   parameter int BIT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ifu_avalid,
   input  logic [BIT_W-1:0] ifu_addr,
   output logic             ifu_rvalid_o,
   output logic [BIT_W-1:0] ifu_rdata_o,
   output logic             ifu_err_o,
   input  logic             lsu_avalid,
   input  logic             lsu_ren,
   input  logic             lsu_wen,
   input  logic [BIT_W-1:0] lsu_addr,
   input  logic [BIT_W-1:0] lsu_wdata,
   input  logic [1:0]       lsu_size,
   input  logic             lsu_signed,
   output logic             lsu_rvalid_o,
   output logic             lsu_wready_o,
   output logic [BIT_W-1:0] lsu_rdata_o,
   output logic             lsu_err_o,
   output logic             mem_arvalid,
   input  logic             mem_arready,
   output logic [BIT_W-1:0] mem_araddr,
   input  logic             mem_rvalid,
   output logic             mem_rready,
   input  logic [BIT_W-1:0] mem_rdata,
   input  logic [1:0]       mem_rresp,
   output logic             mem_awvalid,
   input  logic             mem_awready,
   output logic [BIT_W-1:0] mem_awaddr,
   output logic             mem_wvalid,
   input  logic             mem_wready,
   output logic [BIT_W-1:0] mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic             mem_bvalid,
   output logic             mem_bready,
   input  logic [1:0]       mem_bresp
);

   typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

   state_t           state, state_nxt;
   logic             last_lsu, gnt_lsu, is_load_q;
   logic [BIT_W-1:0] addr_q, wdata_q;
   logic [1:0]       size_q;
   logic             signed_q, err_q, aw_done, w_done;
   logic [3:0]       strb_q;

   logic             any_req, pick_lsu, aw_ok, w_ok;
   logic [1:0]       off;
   logic [3:0]       st_strb;
   logic [BIT_W-1:0] st_data, ld_shift, ld_data;

   // LSU wins a tie only if the IFU was granted last
   assign any_req  = ifu_avalid | lsu_avalid;
   assign pick_lsu = lsu_avalid & (~ifu_avalid | ~last_lsu);
   assign off      = lsu_addr[1:0];
   assign aw_ok    = aw_done | mem_awready;
   assign w_ok     = w_done | mem_wready;

   always_comb begin
      st_strb = 4'hF;
      st_data = lsu_wdata;
      case (lsu_size)
         2'd0: begin
            st_strb = 4'b0001 << off;
            st_data = lsu_wdata << {off, 3'b000};
         end
         2'd1: begin
            st_strb = off[1] ? 4'b1100 : 4'b0011;
            st_data = off[1] ? (lsu_wdata << 16) : lsu_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_shift = mem_rdata;
      ld_data  = mem_rdata;
      case (size_q)
         2'd0: begin
            ld_shift = mem_rdata >> {addr_q[1:0], 3'b000};
            ld_data  = {{(BIT_W-8){signed_q & ld_shift[7]}}, ld_shift[7:0]};
         end
         2'd1: begin
            ld_shift = mem_rdata >> {addr_q[1], 4'b0000};
            ld_data  = {{(BIT_W-16){signed_q & ld_shift[15]}}, ld_shift[15:0]};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               if (!pick_lsu)    state_nxt = AR;
               else if (lsu_wen) state_nxt = AW_W;
               else if (lsu_ren) state_nxt = AR;
               else              state_nxt = RESP;
            end
         end
         AR:      if (mem_arready) state_nxt = R;
         R:       if (mem_rvalid) state_nxt = RESP;
         AW_W:    if (aw_ok && w_ok) state_nxt = B;
         B:       if (mem_bvalid) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are frozen at grant so the masters may change inputs freely
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         last_lsu    <= 1'b0;
         gnt_lsu     <= 1'b0;
         is_load_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= 2'd0;
         signed_q    <= 1'b0;
         strb_q      <= 4'h0;
         err_q       <= 1'b0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         ifu_rdata_o <= '0;
         lsu_rdata_o <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_lsu  <= pick_lsu;
                  last_lsu <= pick_lsu;
                  err_q    <= 1'b0;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
                  if (pick_lsu) begin
                     is_load_q <= ~lsu_wen & lsu_ren;
                     addr_q    <= lsu_addr;
                     size_q    <= lsu_size;
                     signed_q  <= lsu_signed;
                     strb_q    <= st_strb;
                     wdata_q   <= st_data;
                  end else begin
                     is_load_q <= 1'b1;
                     addr_q    <= ifu_addr;
                     size_q    <= 2'd2;
                     signed_q  <= 1'b0;
                     strb_q    <= 4'h0;
                     wdata_q   <= '0;
                  end
               end
            end
            R: begin
               if (mem_rvalid) begin
                  err_q <= |mem_rresp;
                  if (gnt_lsu) lsu_rdata_o <= ld_data;
                  else         ifu_rdata_o <= mem_rdata;
               end
            end
            AW_W: begin
               if (mem_awready) aw_done <= 1'b1;
               if (mem_wready)  w_done  <= 1'b1;
            end
            B: if (mem_bvalid) err_q <= |mem_bresp;
            default: ;
         endcase
      end
   end

   assign mem_arvalid  = (state == AR);
   assign mem_araddr   = addr_q;
   assign mem_rready   = (state == R);
   assign mem_awvalid  = (state == AW_W) & ~aw_done;
   assign mem_awaddr   = addr_q;
   assign mem_wvalid   = (state == AW_W) & ~w_done;
   assign mem_wdata    = wdata_q;
   assign mem_wstrb    = strb_q;
   assign mem_bready   = (state == B);

   assign ifu_rvalid_o = (state == RESP) & ~gnt_lsu;
   assign ifu_err_o    = (state == RESP) & ~gnt_lsu & err_q;
   assign lsu_rvalid_o = (state == RESP) & gnt_lsu & is_load_q;
   assign lsu_wready_o = (state == RESP) & gnt_lsu & ~is_load_q;
   assign lsu_err_o    = (state == RESP) & gnt_lsu & err_q;

endmodule
